// File: rtl/rgmii_tx_ctrl.sv
// rgmii_tx_ctrl: RGMII transmit controller between a GMII-side MAC and the
// output DDR registers of an RGMII PHY interface.
//   - Builds the DDR TX clock pattern for 10/100M with exact 50 % duty for any
//     integer divider, and a fixed 1/0 pattern for 1000M.
//   - Generates the per-period MAC clock enable.
//   - Maps GMII data/control onto the DDR half values.
//   - Defers speed changes until the MAC is idle at the end of a TX clock
//     period, so the line clock never glitches.
//   - Counts frames started (wrapping) and error cycles (saturating).
//
// Ports:
//   clk, rst_n                         125 MHz clock, async active-low reset
//   speed_req[1:0]                     00=10M, 01=100M, 1x=1000M
//   speed_cur[1:0], speed_busy         applied speed, change pending
//   mac_gmii_txd/tx_en/tx_er           MAC transmit inputs
//   mac_gmii_tx_clk_en                 MAC clock enable
//   rgmii_tx_clk_d1/d2                 TX clock oddr half values
//   rgmii_txd_d1/d2[3:0]               data oddr half values
//   rgmii_tx_ctl_d1/d2                 control oddr half values
//   tx_frame_cnt, tx_err_cnt           frame / error counters
//
// state  | meaning
// RUN    | normal operation at speed_cur
// DRAIN  | speed change requested, waiting for idle MAC at end of period
// SWITCH | one cycle: apply new speed, restart period, blank data lanes
module rgmii_tx_ctrl #(
   parameter int         DIV_100M    = 5,
   parameter int         DIV_10M     = 50,
   parameter logic [1:0] RESET_SPEED = 2'b10,
   parameter int         CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       speed_req,
   output logic [1:0]       speed_cur,
   output logic             speed_busy,
   input  logic [7:0]       mac_gmii_txd,
   input  logic             mac_gmii_tx_en,
   input  logic             mac_gmii_tx_er,
   output logic             mac_gmii_tx_clk_en,
   output logic             rgmii_tx_clk_d1,
   output logic             rgmii_tx_clk_d2,
   output logic [3:0]       rgmii_txd_d1,
   output logic [3:0]       rgmii_txd_d2,
   output logic             rgmii_tx_ctl_d1,
   output logic             rgmii_tx_ctl_d2,
   output logic [CNT_W-1:0] tx_frame_cnt,
   output logic [CNT_W-1:0] tx_err_cnt
);

   // Period counter only needs to reach DIV_10M-1; one extra bit is used
   // when comparing 2*cnt(+1) against the divider.
   localparam int CW = (DIV_10M > 2) ? $clog2(DIV_10M) : 1;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_SWITCH = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [1:0]       r_speed;
   logic [1:0]       w_speed_req_n;
   logic [CW-1:0]    r_cnt;
   logic [CW-1:0]    w_cnt_nxt;
   logic [CW:0]      w_div;
   logic             w_is_1g;
   logic             w_last;
   logic             w_clk_en;
   logic             w_tck1;
   logic             w_tck2;

   logic             r_tck1;
   logic             r_tck2;
   logic [3:0]       r_txd1;
   logic [3:0]       r_txd2;
   logic             r_ctl1;
   logic             r_ctl2;
   logic             r_prev_en;
   logic [CNT_W-1:0] r_frame_cnt;
   logic [CNT_W-1:0] r_err_cnt;

   assign w_speed_req_n = (speed_req == 2'b11) ? 2'b10 : speed_req;
   assign w_is_1g       = r_speed[1];
   assign w_div         = (r_speed == 2'b00) ? (CW+1)'(DIV_10M) : (CW+1)'(DIV_100M);
   assign w_last        = ({1'b0, r_cnt} == (w_div - (CW+1)'(1)));

   // Decoded from registers only, so no input-to-enable combinational path.
   assign w_clk_en = (r_state != ST_SWITCH) && (w_is_1g || w_last);

   // Half-cycle resolution: 2*DIV halves per period, the last DIV are high.
   assign w_tck1 = w_is_1g | ({r_cnt, 1'b0} >= w_div);
   assign w_tck2 = ~w_is_1g & ({r_cnt, 1'b1} >= w_div);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_RUN: begin
            if (w_speed_req_n != r_speed) w_state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (w_speed_req_n == r_speed)           w_state_nxt = ST_RUN;
            else if (w_clk_en && !mac_gmii_tx_en)   w_state_nxt = ST_SWITCH;
         end
         ST_SWITCH: w_state_nxt = ST_RUN;
         default:   w_state_nxt = ST_RUN;
      endcase
   end

   always_comb begin
      w_cnt_nxt = r_cnt + CW'(1);
      if ((r_state == ST_SWITCH) || w_is_1g || w_last) w_cnt_nxt = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_RUN;
         r_speed <= RESET_SPEED;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         // Target speed is sampled on the SWITCH cycle itself.
         if (r_state == ST_SWITCH) r_speed <= w_speed_req_n;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tck1 <= 1'b0;
         r_tck2 <= 1'b0;
         r_txd1 <= '0;
         r_txd2 <= '0;
         r_ctl1 <= 1'b0;
         r_ctl2 <= 1'b0;
      end else if (r_state == ST_SWITCH) begin
         // Clock halves keep the end-of-period value across the switch.
         r_txd1 <= '0;
         r_txd2 <= '0;
         r_ctl1 <= 1'b0;
         r_ctl2 <= 1'b0;
      end else begin
         r_tck1 <= w_tck1;
         r_tck2 <= w_tck2;
         r_txd1 <= mac_gmii_txd[3:0];
         if (w_is_1g) begin
            r_txd2 <= mac_gmii_txd[7:4];
            r_ctl1 <= mac_gmii_tx_en;
            r_ctl2 <= mac_gmii_tx_en ^ mac_gmii_tx_er;
         end else begin
            // At 10/100M each half carries tx_en while the clock is low and
            // tx_en^tx_er while it is high.
            r_txd2 <= mac_gmii_txd[3:0];
            r_ctl1 <= w_tck1 ? (mac_gmii_tx_en ^ mac_gmii_tx_er) : mac_gmii_tx_en;
            r_ctl2 <= w_tck2 ? (mac_gmii_tx_en ^ mac_gmii_tx_er) : mac_gmii_tx_en;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prev_en   <= 1'b0;
         r_frame_cnt <= '0;
         r_err_cnt   <= '0;
      end else if (w_clk_en) begin
         r_prev_en <= mac_gmii_tx_en;
         if (mac_gmii_tx_en && !r_prev_en)
            r_frame_cnt <= r_frame_cnt + CNT_W'(1);
         if (mac_gmii_tx_en && mac_gmii_tx_er && (r_err_cnt != '1))
            r_err_cnt <= r_err_cnt + CNT_W'(1);
      end
   end

   assign speed_cur          = r_speed;
   assign speed_busy         = (r_state != ST_RUN);
   assign mac_gmii_tx_clk_en = w_clk_en;
   assign rgmii_tx_clk_d1    = r_tck1;
   assign rgmii_tx_clk_d2    = r_tck2;
   assign rgmii_txd_d1       = r_txd1;
   assign rgmii_txd_d2       = r_txd2;
   assign rgmii_tx_ctl_d1    = r_ctl1;
   assign rgmii_tx_ctl_d2    = r_ctl2;
   assign tx_frame_cnt       = r_frame_cnt;
   assign tx_err_cnt         = r_err_cnt;

endmodule
